// File: rtl/stage_sequencer.sv
// stage_sequencer: launches NUM_STAGES compute stages in order, with start/continuous/abort control, a watchdog, run counting and latency capture.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a run (sampled in IDLE or ERROR)
//   mode_continuous   latched at launch; 1 = relaunch after every completed run
//   abort             terminate the current run
//   timeout_limit     per-stage cycle limit, 0 disables the watchdog
//   stage_done        level done from each stage
//   stage_reset       one-cycle launch / quiesce pulses
//   cur_stage         index of the active stage
//   busy              high while waiting on a stage
//   done              one-cycle pulse when the last stage completes
//   timeout_err       sticky watchdog flag, cleared by the next launch
//   run_count         completed runs (wraps)
//   last_latency      launch-to-done cycles of the last completed run (saturating)
module stage_sequencer #(
    parameter int NUM_STAGES    = 2,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int LAT_WIDTH     = 32,
    parameter int RUN_WIDTH     = 16,
    parameter int AUTO_START    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode_continuous,
    input  logic                          abort,
    input  logic [TIMEOUT_WIDTH-1:0]      timeout_limit,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_reset,
    output logic [$clog2(NUM_STAGES):0]   cur_stage,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic [RUN_WIDTH-1:0]          run_count,
    output logic [LAT_WIDTH-1:0]          last_latency
);
    localparam int CW = $clog2(NUM_STAGES) + 1;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ERROR = 2'd2;
    logic [1:0] state;
    logic mode_q, auto_q;
    logic [TIMEOUT_WIDTH-1:0] wd_cnt, wd_inc;
    logic [LAT_WIDTH-1:0] lat_cnt, lat_inc;
    logic [NUM_STAGES-1:0] sel;
    logic accept, last, hit, go;
    // A done bit is only trusted once the stage's own launch pulse has passed,
    // so a level left over from the previous run cannot be taken as completion.
    // The watchdog fires in the cycle whose count increment would reach the limit.
    always_comb begin
        sel = NUM_STAGES'(1) << cur_stage;
        accept = |(stage_done & sel & ~stage_reset);
        last = cur_stage == CW'(NUM_STAGES - 1);
        wd_inc = &wd_cnt ? wd_cnt : wd_cnt + TIMEOUT_WIDTH'(1);
        lat_inc = &lat_cnt ? lat_cnt : lat_cnt + LAT_WIDTH'(1);
        hit = timeout_limit != '0 && ({1'b0, wd_cnt} + (TIMEOUT_WIDTH+1)'(1)) == {1'b0, timeout_limit};
        go = (start || auto_q) && !abort;
    end
    assign busy = state == WAIT;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mode_q <= 1'b0;
            auto_q <= AUTO_START != 0;
            wd_cnt <= '0;
            lat_cnt <= '0;
            stage_reset <= '0;
            cur_stage <= '0;
            done <= 1'b0;
            timeout_err <= 1'b0;
            run_count <= '0;
            last_latency <= '0;
        end else begin
            auto_q <= 1'b0;
            stage_reset <= '0;
            done <= 1'b0;
            if (state != WAIT) begin
                if (go) begin
                    state <= WAIT;
                    mode_q <= mode_continuous && !auto_q;
                    stage_reset <= NUM_STAGES'(1);
                    cur_stage <= '0;
                    wd_cnt <= '0;
                    lat_cnt <= '0;
                    timeout_err <= 1'b0;
                end
            end else if (abort) begin
                state <= IDLE;
                stage_reset <= '1;
                cur_stage <= '0;
            end else if (accept && !last) begin
                stage_reset <= sel << 1;
                cur_stage <= cur_stage + CW'(1);
                wd_cnt <= '0;
                lat_cnt <= lat_inc;
            end else if (accept) begin
                done <= 1'b1;
                run_count <= run_count + RUN_WIDTH'(1);
                last_latency <= lat_inc;
                cur_stage <= '0;
                wd_cnt <= '0;
                lat_cnt <= '0;
                if (mode_q) stage_reset <= NUM_STAGES'(1);
                else state <= IDLE;
            end else if (hit) begin
                state <= ERROR;
                timeout_err <= 1'b1;
                stage_reset <= '1;
                cur_stage <= '0;
            end else begin
                wd_cnt <= wd_inc;
                lat_cnt <= lat_inc;
            end
        end
    end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the top-level run controller for the arbitrage engine.
- Launches NUM_STAGES compute stages strictly in order, for example Bellman relaxation followed by cycle detection. Each stage gets a one-cycle reset pulse and the sequencer waits for that stage's done.
- Adds explicit start, continuous re-run mode, abort, per-stage watchdog timeout, run counting and run-latency capture.
- Sits between the host/register interface and the stage modules.

Parameters:
- NUM_STAGES, 2: number of sequential stages; must be ≥1.
- TIMEOUT_WIDTH, 16: width of the per-stage watchdog limit and counter.
- LAT_WIDTH, 32: width of the run-latency counter; saturating.
- RUN_WIDTH, 16: width of the completed-run counter; wraps.
- AUTO_START, 1: 1 = behave as if start=1, mode_continuous=0 in the first cycle after reset deasserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE or ERROR
- mode_continuous  in  1  latched at start; 1 = relaunch after every completed run
- abort  in  1  terminate the current run
- timeout_limit  in  TIMEOUT_WIDTH  per-stage cycle limit; 0 disables the watchdog
- stage_done  in  NUM_STAGES  level done from each stage
- stage_reset  out  NUM_STAGES  one-cycle launch/quiesce pulses
- cur_stage  out  $clog2(NUM_STAGES)+1  index of the active stage
- busy  out  1  high in WAIT
- done  out  1  one-cycle pulse when the last stage completes
- timeout_err  out  1  sticky; watchdog fired
- run_count  out  RUN_WIDTH  number of completed runs
- last_latency  out  LAT_WIDTH  cycles from launch of stage 0 to the done pulse of the last completed run

Behaviour:
- **Reset values:** all outputs 0, state IDLE, latched mode 0, counters 0. Reset asserted mid-run overrides everything, and stage_reset is not pulsed by reset itself.
- **States:** IDLE, WAIT, ERROR.
- **Launch:**
  - In IDLE/ERROR, start=1 produces, in the next cycle: stage_reset[0]=1 for exactly one cycle, cur_stage=0, state WAIT, busy=1, timeout_err=0, and the watchdog and latency counters cleared to 0.
  - mode_continuous is latched in the same cycle.
  - With AUTO_START=1, the first cycle after reset deasserts is treated as start with mode 0.
- **WAIT:**
  - Only stage_done[cur_stage] is examined; all other done bits are ignored.
  - stage_done is ignored in the cycle in which stage_reset[cur_stage] is high, so stale done from a previous run is not accepted.
  - The watchdog counter increments every WAIT cycle and restarts at 0 on each stage launch.
  - The latency counter increments every WAIT cycle and saturates at all-ones.
- **Advance:** when done is accepted for stage k < NUM_STAGES-1, the next cycle has stage_reset[k+1]=1 and cur_stage=k+1. This costs one cycle per stage boundary.
- **Completion:** when done is accepted for the last stage, the next cycle has:
  - done=1 for one cycle;
  - run_count incremented (wraps);
  - last_latency set to the latency counter value + 1.
  - Then:
    - If latched mode=1 and abort=0: stage_reset[0]=1 in that same cycle, cur_stage=0, counters cleared, state remains WAIT.
    - Otherwise: state IDLE, busy=0, cur_stage=0.
- **Watchdog:**
  - Fires when timeout_limit≠0 and the watchdog counter reaches timeout_limit with no accepted done.
  - Next cycle: timeout_err=1, state ERROR, busy=0, and stage_reset is asserted on all bits for one cycle to quiesce.
  - If done and the limit are hit in the same cycle, done wins.
- **Abort:**
  - Priority is below reset and above done and timeout.
  - In WAIT: next cycle has state IDLE, busy=0, all stage_reset bits=1 for one cycle, no done pulse, and run_count and last_latency unchanged.
  - In IDLE/ERROR: no effect. abort and start in the same cycle: abort wins and no launch occurs.
- **Ignored starts:** start while in WAIT is ignored; mode_continuous changes during WAIT are ignored.

Test Plan:
- NUM_STAGES=2, AUTO_START=1; release reset; raise stage_done[0] 10 cycles after its pulse, then stage_done[1] 5 cycles after its pulse. Required: stage_reset pulses at cycles 1 and 12, done at cycle 18, run_count=1, last_latency=17, final state IDLE.
- Continuous mode, NUM_STAGES=3, each stage done 4 cycles after its launch pulse. Required: done pulses every 15 cycles, stage_reset[0] coincident with each done, run_count=3 after 3 runs. Then assert abort: busy=0, all stage_reset bits high for one cycle, run_count remains 3.
- timeout_limit=8, stage 1 never raises done. Required: 8 WAIT cycles after stage 1 launch, timeout_err=1, state ERROR, all stage_reset bits pulsed. A following start clears timeout_err and relaunches stage 0.
- Stage done held high from a prior run while its stage_reset pulses. Required: the done is not accepted in the pulse cycle, and the sequencer advances only if done is still high on the next cycle. Also, stage_done[1] raised while cur_stage=0 must be ignored.
- Corner cases:
  - done of the last stage on the same cycle as the timeout limit: done pulses and timeout_err stays 0.
  - abort together with start in IDLE: no launch.
  - reset asserted mid-WAIT: all outputs 0 next cycle.
- run_count wrap with RUN_WIDTH=2 over 5 runs: run_count ends at 1.
- last_latency saturation with LAT_WIDTH=4 and a 20-cycle run: last_latency=15.
